// File: rtl/abs_share_arb.sv
// Purpose: round-robin arbiter sharing one absolute-value datapath among NREQ requesters.
// Latency: 2 cycles from operand acceptance to res_valid (operand reg -> result reg).
// Backpressure: res_ready low stalls stage 2, then stage 1; req_ready drops once both stages are full.
//
// Ports:
//   clk, reset              clock, asynchronous active-high reset
//   req_valid/req_data      per-requester operands (requester i at bits [W*i +: W])
//   req_ready               one-hot grant, combinational; transfer = req_valid & req_ready
//   req_mask                requester i is never granted while req_mask[i] is high
//   res_valid/res_ready     result handshake
//   res_data/res_id/res_ovf |operand|, owning requester, operand was the most negative value
//   busy                    either pipeline stage holds data

// Combinational two's-complement magnitude. The most negative value has no
// positive counterpart; its negation wraps back to itself, which is also the
// correct unsigned magnitude, so only the flag needs special handling.
module abs26 #(
    parameter int W = 26
) (
    input  logic [W-1:0] operand,
    output logic [W-1:0] magnitude,
    output logic         ovf
);
    assign magnitude = operand[W-1] ? (~operand + W'(1)) : operand;
    assign ovf       = (operand == {1'b1, {(W-1){1'b0}}});
endmodule

module abs_share_arb #(
    parameter int NREQ = 4,
    parameter int W    = 26
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NREQ-1:0]            req_valid,
    input  logic [NREQ*W-1:0]          req_data,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ-1:0]            req_mask,
    output logic                       res_valid,
    output logic [W-1:0]               res_data,
    output logic [$clog2(NREQ)-1:0]    res_id,
    output logic                       res_ovf,
    input  logic                       res_ready,
    output logic                       busy
);
    localparam int IDW = $clog2(NREQ);

    // Stage 1: operand register.
    logic           valid1;
    logic [W-1:0]   op1;
    logic [IDW-1:0] id1;

    // Round-robin pointer: the search starts just after this requester.
    logic [IDW-1:0] lastGrant;

    logic           load2;
    logic           canAccept;
    logic [NREQ-1:0] eligible;
    logic           found;
    logic [IDW-1:0] grantIdx;
    logic [IDW-1:0] idx;
    logic [W-1:0]   selData;
    logic [W-1:0]   absMag;
    logic           absOvf;

    // Stage 2 reloads whenever it is empty or its content is leaving; an
    // empty stage 1 then simply loads a bubble.
    assign load2     = !res_valid || res_ready;
    assign canAccept = !valid1 || load2;

    // Reset gating keeps req_ready low for the whole time reset is held.
    assign eligible = req_valid & ~req_mask & {NREQ{canAccept & ~reset}};

    // Priority search over rotated indices; IDW-bit arithmetic wraps modulo NREQ
    // (NREQ is a power of two).
    always_comb begin
        found    = 1'b0;
        grantIdx = '0;
        idx      = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = lastGrant + IDW'(k + 1);
            if (!found && eligible[idx]) begin
                found    = 1'b1;
                grantIdx = idx;
            end
        end
    end

    assign req_ready = found ? (NREQ'(1) << grantIdx) : '0;
    assign selData   = req_data[grantIdx*W +: W];
    assign busy      = valid1 || res_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid1    <= 1'b0;
            op1       <= '0;
            id1       <= '0;
            lastGrant <= IDW'(NREQ - 1);
        end else begin
            if (found) begin
                valid1    <= 1'b1;
                op1       <= selData;
                id1       <= grantIdx;
                lastGrant <= grantIdx;
            end else if (load2) begin
                valid1    <= 1'b0;
            end
        end
    end

    abs26 #(.W(W)) uAbs (
        .operand   (op1),
        .magnitude (absMag),
        .ovf       (absOvf)
    );

    // Payload only changes when a real result arrives, so a bubble leaves the
    // last result's fields untouched.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_valid <= 1'b0;
            res_data  <= '0;
            res_id    <= '0;
            res_ovf   <= 1'b0;
        end else if (load2) begin
            res_valid <= valid1;
            if (valid1) begin
                res_data <= absMag;
                res_id   <= id1;
                res_ovf  <= absOvf;
            end
        end
    end
endmodule

// File: tb/tb_abs_share_arb.sv
module tb_abs_share_arb;
    logic         clk;
    logic         reset;
    logic [3:0]   req_valid;
    logic [103:0] req_data;
    logic [3:0]   req_ready;
    logic [3:0]   req_mask;
    logic         res_valid;
    logic [25:0]  res_data;
    logic [1:0]   res_id;
    logic         res_ovf;
    logic         res_ready;
    logic         busy;

    int passCnt = 0;
    int totCnt  = 0;

    abs_share_arb #(.NREQ(4), .W(26)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .req_mask  (req_mask),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_id    (res_id),
        .res_ovf   (res_ovf),
        .res_ready (res_ready),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]   valid;
        logic [3:0]   mask;
        logic [103:0] data;
        logic         resReady;
        logic [3:0]   expReady;
        logic         expResValid;
        logic [25:0]  expData;
        logic [1:0]   expId;
        logic         expOvf;
        logic         expBusy;
    } vec_t;

    vec_t vecs[24];

    function automatic logic [103:0] pack4(logic [25:0] d0, logic [25:0] d1,
                                           logic [25:0] d2, logic [25:0] d3);
        return {d3, d2, d1, d0};
    endfunction

    function automatic vec_t mk(logic [3:0] v, logic [3:0] m, logic [103:0] d,
                                logic rr, logic [3:0] er, logic erv,
                                logic [25:0] ed, logic [1:0] eid, logic eo, logic eb);
        vec_t r;
        r.valid = v; r.mask = m; r.data = d; r.resReady = rr;
        r.expReady = er; r.expResValid = erv; r.expData = ed;
        r.expId = eid; r.expOvf = eo; r.expBusy = eb;
        return r;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        totCnt++;
        if (act === exp) passCnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    logic [103:0] dS, dB0, dB1, dB2, dF;
    logic [25:0]  bpOp[8];
    logic [25:0]  bpExp[8];
    int           sent, rcv;
    logic         accepted;

    initial begin
        dS  = pack4(26'h3FFFFFB, 26'h0, 26'h0, 26'h0);
        dB0 = pack4(26'h0, 26'h0, 26'h0, 26'h0);
        dB1 = pack4(26'h0, 26'h1FFFFFF, 26'h0, 26'h0);
        dB2 = pack4(26'h0, 26'h2000000, 26'h0, 26'h0);
        dF  = pack4(26'h3FFFFFF, 26'd2, 26'h3FFFFFD, 26'd4);

        //             valid  mask  data rr ready  rv data          id ovf busy
        // single op: -5 on requester 0
        vecs[0]  = mk(4'h1, 4'h0, dS,  1, 4'h1, 0, 26'd0,        0, 0, 0);
        vecs[1]  = mk(4'h0, 4'h0, dS,  1, 4'h0, 0, 26'd0,        0, 0, 1);
        vecs[2]  = mk(4'h0, 4'h0, dS,  1, 4'h0, 1, 26'd5,        0, 0, 1);
        vecs[3]  = mk(4'h0, 4'h0, dS,  1, 4'h0, 0, 26'd0,        0, 0, 0);
        // boundaries on requester 1, back to back
        vecs[4]  = mk(4'h2, 4'h0, dB0, 1, 4'h2, 0, 26'd0,        0, 0, 0);
        vecs[5]  = mk(4'h2, 4'h0, dB1, 1, 4'h2, 0, 26'd0,        0, 0, 1);
        vecs[6]  = mk(4'h2, 4'h0, dB2, 1, 4'h2, 1, 26'd0,        1, 0, 1);
        vecs[7]  = mk(4'h0, 4'h0, dB2, 1, 4'h0, 1, 26'h1FFFFFF,  1, 0, 1);
        vecs[8]  = mk(4'h0, 4'h0, dB2, 1, 4'h0, 1, 26'h2000000,  1, 1, 1);
        vecs[9]  = mk(4'h0, 4'h0, dB2, 1, 4'h0, 0, 26'd0,        0, 0, 0);
        // fairness: last grant 1, so order 2,3,0,1,2
        vecs[10] = mk(4'hF, 4'h0, dF,  1, 4'h4, 0, 26'd0,        0, 0, 0);
        vecs[11] = mk(4'hF, 4'h0, dF,  1, 4'h8, 0, 26'd0,        0, 0, 1);
        vecs[12] = mk(4'hF, 4'h0, dF,  1, 4'h1, 1, 26'd3,        2, 0, 1);
        vecs[13] = mk(4'hF, 4'h0, dF,  1, 4'h2, 1, 26'd4,        3, 0, 1);
        vecs[14] = mk(4'hF, 4'h0, dF,  1, 4'h4, 1, 26'd1,        0, 0, 1);
        vecs[15] = mk(4'h0, 4'h0, dF,  1, 4'h0, 1, 26'd2,        1, 0, 1);
        vecs[16] = mk(4'h0, 4'h0, dF,  1, 4'h0, 1, 26'd3,        2, 0, 1);
        vecs[17] = mk(4'h0, 4'h0, dF,  1, 4'h0, 0, 26'd0,        0, 0, 0);
        // mask 0101: only 1 and 3, alternating, starting at 3
        vecs[18] = mk(4'hF, 4'h5, dF,  1, 4'h8, 0, 26'd0,        0, 0, 0);
        vecs[19] = mk(4'hF, 4'h5, dF,  1, 4'h2, 0, 26'd0,        0, 0, 1);
        vecs[20] = mk(4'hF, 4'h5, dF,  1, 4'h8, 1, 26'd4,        3, 0, 1);
        vecs[21] = mk(4'h0, 4'h5, dF,  1, 4'h0, 1, 26'd2,        1, 0, 1);
        vecs[22] = mk(4'h0, 4'h5, dF,  1, 4'h0, 1, 26'd4,        3, 0, 1);
        vecs[23] = mk(4'h0, 4'h5, dF,  1, 4'h0, 0, 26'd0,        0, 0, 0);

        for (int k = 0; k < 8; k++) begin
            bpExp[k] = 26'(k + 10);
            bpOp[k]  = (k % 2 == 1) ? (~bpExp[k] + 26'd1) : bpExp[k];
        end

        // Reset state, with requesters already valid.
        reset = 1'b1; req_valid = 4'hF; req_mask = 4'h0; req_data = dF; res_ready = 1'b1;
        #2;
        check("reset res_valid", 32'(res_valid), 0);
        check("reset busy", 32'(busy), 0);
        check("reset req_ready", 32'(req_ready), 0);
        check("reset res_data", 32'(res_data), 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0; req_valid = 4'h0;

        // Table-driven section, one row per cycle.
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            req_valid = vecs[i].valid;
            req_mask  = vecs[i].mask;
            req_data  = vecs[i].data;
            res_ready = vecs[i].resReady;
            #1;
            check($sformatf("row%0d req_ready", i), 32'(req_ready), 32'(vecs[i].expReady));
            check($sformatf("row%0d res_valid", i), 32'(res_valid), 32'(vecs[i].expResValid));
            check($sformatf("row%0d busy", i), 32'(busy), 32'(vecs[i].expBusy));
            if (vecs[i].expResValid) begin
                check($sformatf("row%0d res_data", i), 32'(res_data), 32'(vecs[i].expData));
                check($sformatf("row%0d res_id", i), 32'(res_id), 32'(vecs[i].expId));
                check($sformatf("row%0d res_ovf", i), 32'(res_ovf), 32'(vecs[i].expOvf));
            end
        end

        // Backpressure: 8 operands from requester 0, res_ready low in cycles 3..7.
        sent = 0; rcv = 0;
        req_mask = 4'h0;
        for (int c = 0; c < 40 && rcv < 8; c++) begin
            @(negedge clk);
            req_valid = (sent < 8) ? 4'h1 : 4'h0;
            req_data  = pack4(bpOp[(sent < 8) ? sent : 0], 26'h0, 26'h0, 26'h0);
            res_ready = !(c >= 3 && c <= 7);
            #1;
            if (c >= 3 && c <= 7) begin
                check($sformatf("bp stall%0d req_ready", c), 32'(req_ready), 0);
                check($sformatf("bp stall%0d res_valid", c), 32'(res_valid), 1);
            end
            if (res_valid) begin
                if (rcv < 8) begin
                    check($sformatf("bp res%0d data", rcv), 32'(res_data), 32'(bpExp[rcv]));
                    check($sformatf("bp res%0d id", rcv), 32'(res_id), 0);
                    if (res_ready) rcv++;
                end else begin
                    check("bp extra result", 32'(rcv), 8);
                end
            end
            accepted = req_valid[0] && req_ready[0];
            @(posedge clk);
            if (accepted) sent++;
        end
        check("bp results received", 32'(rcv), 8);
        check("bp operands sent", 32'(sent), 8);

        // Reset mid-operation with both stages full; last grant is 0 beforehand.
        @(negedge clk);
        req_valid = 4'h1; req_data = pack4(26'h3FFFFF0, 26'h0, 26'h0, 26'h0); res_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("full res_valid", 32'(res_valid), 1);
        check("full req_ready", 32'(req_ready), 0);
        reset = 1'b1; req_valid = 4'hF;
        #1;
        check("midreset res_valid", 32'(res_valid), 0);
        check("midreset busy", 32'(busy), 0);
        check("midreset req_ready", 32'(req_ready), 0);
        @(negedge clk);
        reset = 1'b0; res_ready = 1'b1;
        req_data = pack4(26'h3FFFFF0, 26'd7, 26'd7, 26'd7);
        #1;
        check("post-reset grant", 32'(req_ready), 32'h1);
        @(negedge clk);
        req_valid = 4'h0;
        #1;
        check("post-reset busy", 32'(busy), 1);
        check("post-reset res_valid early", 32'(res_valid), 0);
        @(negedge clk);
        #1;
        check("post-reset res_valid", 32'(res_valid), 1);
        check("post-reset res_data", 32'(res_data), 32'h10);
        check("post-reset res_id", 32'(res_id), 0);

        $display("%0d/%0d checks passed", passCnt, totCnt);
        $finish;
    end
endmodule
